// File: rtl/pkt_release_ctrl.sv
// Releases buffered packets from the holding FIFO once their lookup result is queued, forwarding
// them with the IOQ header dst-port rewritten or draining them. Optional wait timeout: PKT_RELEASE_TIMEOUT_EN.
module pkt_release_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int RESULT_DEPTH   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  result_valid,
    input  logic                  result_drop,
    input  logic [7:0]            result_port,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic [CTRL_WIDTH-1:0] fifo_ctrl,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  result_overflow,
    output logic [31:0]           pkt_fwd_count,
    output logic [31:0]           pkt_drop_count
);
    localparam int AW = $clog2(RESULT_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(RESULT_DEPTH);
    localparam logic [CTRL_WIDTH-1:0] HDR_CTRL = '1;

    typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;
    state_t state, state_next;

    logic [7:0]    q_port [RESULT_DEPTH];
    logic          q_drop [RESULT_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   q_count;
    logic          q_empty, q_full, q_push, q_pop;
    logic [7:0]    cur_port;
    logic          prev_ctrl_zero, start_pkt, eop, timed_out;

    assign q_empty   = (q_count == '0);
    assign q_full    = (q_count == FULL_COUNT);
    assign start_pkt = (state == IDLE) && !fifo_empty && !q_empty;
    assign q_pop     = start_pkt;
    assign q_push    = result_valid && (!q_full || q_pop);
    assign eop       = fifo_rd_en && (fifo_ctrl != '0) && prev_ctrl_zero;

`ifdef PKT_RELEASE_TIMEOUT_EN
    logic [31:0] wait_count;
    logic        waiting;

    assign waiting   = (state == IDLE) && !fifo_empty && q_empty;
    assign timed_out = waiting && (wait_count == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_count <= '0;
        else if (waiting && !timed_out)
            wait_count <= wait_count + 32'd1;
        else
            wait_count <= '0;
    end
`else
    assign timed_out = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_pkt)
                    state_next = (q_drop[rd_ptr] || q_port[rd_ptr] == 8'h00) ? DROP : FORWARD;
                else if (timed_out)
                    state_next = DROP;
            end
            FORWARD, DROP: if (eop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        unique case (state)
            FORWARD: fifo_rd_en = !fifo_empty && out_rdy;
            DROP:    fifo_rd_en = !fifo_empty;
            default: fifo_rd_en = 1'b0;
        endcase
    end

    // NOTE: result storage is left unreset; q_count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_port[wr_ptr] <= result_port;
            q_drop[wr_ptr] <= result_drop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            q_count         <= '0;
            result_overflow <= 1'b0;
        end else begin
            if (q_push) wr_ptr <= wr_ptr + 1'b1;
            if (q_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({q_push, q_pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            if (result_valid && !q_push) result_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr         <= 1'b0;
            out_data       <= '0;
            out_ctrl       <= '0;
            cur_port       <= '0;
            prev_ctrl_zero <= 1'b0;
            pkt_fwd_count  <= '0;
            pkt_drop_count <= '0;
        end else begin
            out_wr <= (state == FORWARD) && fifo_rd_en;
            if (q_pop) cur_port <= q_port[rd_ptr];
            if ((state == FORWARD) && fifo_rd_en) begin
                out_ctrl <= fifo_ctrl;
                // Module header carries the dst-port field in its top 16 bits.
                if (fifo_ctrl == HDR_CTRL)
                    out_data <= {8'h00, cur_port, fifo_data[DATA_WIDTH-17:0]};
                else
                    out_data <= fifo_data;
            end
            if (state_next == IDLE)
                prev_ctrl_zero <= 1'b0;
            else if (fifo_rd_en)
                prev_ctrl_zero <= (fifo_ctrl == '0);
            if (eop && state == FORWARD) pkt_fwd_count  <= pkt_fwd_count + 32'd1;
            if (eop && state == DROP)    pkt_drop_count <= pkt_drop_count + 32'd1;
        end
    end

endmodule
